// File: rtl/sprite_fetch_scheduler_pkg.sv
// Shared types and constants for the sprite fetch scheduler and its address generator.
package sprite_fetch_scheduler_pkg;

    localparam int unsigned COORD_W        = 10;
    localparam int unsigned SUM_W          = 11;
    localparam int unsigned PROD_W         = 20;
    localparam int unsigned DATA_W         = 8;
    localparam int unsigned ADDR_W_DEF     = 16;
    localparam logic [7:0]  TRANSPARENT_KEY_DEF = 8'b11111011;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FETCH_P1 = 2'd1,
        FETCH_P2 = 2'd2,
        CAPTURE  = 2'd3
    } state_t;

    // Per-frame sprite geometry shared by both players.
    typedef struct packed {
        logic [COORD_W-1:0] p1_posx;
        logic [COORD_W-1:0] p1_posy;
        logic [COORD_W-1:0] p2_posx;
        logic [COORD_W-1:0] p2_posy;
        logic [COORD_W-1:0] width;
        logic [COORD_W-1:0] height;
    } geom_t;

endpackage

// File: rtl/sprite_addr_gen.sv
// Combinational inside test and ROM address for one sprite at one pixel.
module sprite_addr_gen
    import sprite_fetch_scheduler_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  logic [COORD_W-1:0] posx,
    input  logic [COORD_W-1:0] posy,
    input  logic [COORD_W-1:0] width,
    input  logic [COORD_W-1:0] height,
    input  logic [ADDR_W-1:0]  base,
    output logic               inside_c,
    output logic [ADDR_W-1:0]  addr_c
);

    logic [SUM_W-1:0]   x_end;
    logic [SUM_W-1:0]   y_end;
    logic [COORD_W-1:0] dx;
    logic [COORD_W-1:0] dy;
    logic [PROD_W-1:0]  offset;

    // Right/bottom edges are widened by one bit so they never wrap past 1023.
    always_comb begin
        x_end    = SUM_W'(posx) + SUM_W'(width);
        y_end    = SUM_W'(posy) + SUM_W'(height);
        inside_c = (x >= posx) && (SUM_W'(x) < x_end) &&
                   (y >= posy) && (SUM_W'(y) < y_end);
        dx       = x - posx;
        dy       = y - posy;
        offset   = PROD_W'(dy) * PROD_W'(width) + PROD_W'(dx);
        addr_c   = base + ADDR_W'(offset);
    end

endmodule

// File: rtl/sprite_fetch_scheduler.sv
// Time-shares one ROM port between two player sprites, producing one result per pixel.
module sprite_fetch_scheduler
    import sprite_fetch_scheduler_pkg::*;
#(
    parameter int unsigned ADDR_W          = ADDR_W_DEF,
    parameter logic [7:0]  TRANSPARENT_KEY = TRANSPARENT_KEY_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pixel_tick,
    input  logic               frame_start,
    input  logic [COORD_W-1:0] current_pixel_x,
    input  logic [COORD_W-1:0] current_pixel_y,
    input  logic [COORD_W-1:0] p1_posx,
    input  logic [COORD_W-1:0] p1_posy,
    input  logic [COORD_W-1:0] p2_posx,
    input  logic [COORD_W-1:0] p2_posy,
    input  logic [COORD_W-1:0] sprite_width,
    input  logic [COORD_W-1:0] sprite_height,
    input  logic [ADDR_W-1:0]  p1_frame_base,
    input  logic [ADDR_W-1:0]  p2_frame_base,
    output logic [ADDR_W-1:0]  rom_addr,
    output logic               rom_en,
    input  logic [DATA_W-1:0]  rom_data,
    output logic [DATA_W-1:0]  p1_pixel_data,
    output logic [DATA_W-1:0]  p2_pixel_data,
    output logic               p1_inside,
    output logic               p1_visible,
    output logic               p2_inside,
    output logic               p2_visible,
    output logic [COORD_W-1:0] out_pixel_x,
    output logic [COORD_W-1:0] out_pixel_y,
    output logic               out_valid,
    output logic               overrun
);

    state_t              state, state_nx;
    geom_t               geom_q, geom_nx, geom_in, geom_eff;
    logic [ADDR_W-1:0]   base1_q, base1_nx, base2_q, base2_nx, base1_eff, base2_eff;
    logic [COORD_W-1:0]  lat_x, lat_x_nx, lat_y, lat_y_nx, pix_x, pix_y;
    logic                p1_in_q, p1_in_nx, p2_in_q, p2_in_nx;
    logic [DATA_W-1:0]   p1_data_q, p1_data_nx;
    logic                load_c;
    logic                p1_inside_c, p2_inside_c;
    logic [ADDR_W-1:0]   p1_addr_c, p2_addr_c;

    logic [ADDR_W-1:0]   rom_addr_nx;
    logic                rom_en_nx;
    logic [DATA_W-1:0]   p1_pixel_data_nx, p2_pixel_data_nx;
    logic                p1_inside_nx, p1_visible_nx, p2_inside_nx, p2_visible_nx;
    logic [COORD_W-1:0]  out_pixel_x_nx, out_pixel_y_nx;
    logic                out_valid_nx, overrun_nx;

    // A frame load coinciding with a tick must already steer that pixel's address.
    always_comb begin
        load_c    = (state == IDLE) && frame_start;
        geom_in   = '{p1_posx: p1_posx, p1_posy: p1_posy, p2_posx: p2_posx,
                      p2_posy: p2_posy, width: sprite_width, height: sprite_height};
        geom_eff  = load_c ? geom_in : geom_q;
        base1_eff = load_c ? p1_frame_base : base1_q;
        base2_eff = load_c ? p2_frame_base : base2_q;
        pix_x     = (state == IDLE) ? current_pixel_x : lat_x;
        pix_y     = (state == IDLE) ? current_pixel_y : lat_y;
    end

    sprite_addr_gen #(.ADDR_W(ADDR_W)) u_p1_gen (
        .x(pix_x), .y(pix_y), .posx(geom_eff.p1_posx), .posy(geom_eff.p1_posy),
        .width(geom_eff.width), .height(geom_eff.height), .base(base1_eff),
        .inside_c(p1_inside_c), .addr_c(p1_addr_c)
    );

    sprite_addr_gen #(.ADDR_W(ADDR_W)) u_p2_gen (
        .x(pix_x), .y(pix_y), .posx(geom_eff.p2_posx), .posy(geom_eff.p2_posy),
        .width(geom_eff.width), .height(geom_eff.height), .base(base2_eff),
        .inside_c(p2_inside_c), .addr_c(p2_addr_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            geom_q        <= '0;
            base1_q       <= '0;
            base2_q       <= '0;
            lat_x         <= '0;
            lat_y         <= '0;
            p1_in_q       <= 1'b0;
            p2_in_q       <= 1'b0;
            p1_data_q     <= '0;
            rom_addr      <= '0;
            rom_en        <= 1'b0;
            p1_pixel_data <= '0;
            p2_pixel_data <= '0;
            p1_inside     <= 1'b0;
            p1_visible    <= 1'b0;
            p2_inside     <= 1'b0;
            p2_visible    <= 1'b0;
            out_pixel_x   <= '0;
            out_pixel_y   <= '0;
            out_valid     <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            state         <= state_nx;
            geom_q        <= geom_nx;
            base1_q       <= base1_nx;
            base2_q       <= base2_nx;
            lat_x         <= lat_x_nx;
            lat_y         <= lat_y_nx;
            p1_in_q       <= p1_in_nx;
            p2_in_q       <= p2_in_nx;
            p1_data_q     <= p1_data_nx;
            rom_addr      <= rom_addr_nx;
            rom_en        <= rom_en_nx;
            p1_pixel_data <= p1_pixel_data_nx;
            p2_pixel_data <= p2_pixel_data_nx;
            p1_inside     <= p1_inside_nx;
            p1_visible    <= p1_visible_nx;
            p2_inside     <= p2_inside_nx;
            p2_visible    <= p2_visible_nx;
            out_pixel_x   <= out_pixel_x_nx;
            out_pixel_y   <= out_pixel_y_nx;
            out_valid     <= out_valid_nx;
            overrun       <= overrun_nx;
        end
    end

    always_comb begin
        state_nx         = state;
        geom_nx          = load_c ? geom_in : geom_q;
        base1_nx         = base1_eff;
        base2_nx         = base2_eff;
        lat_x_nx         = lat_x;
        lat_y_nx         = lat_y;
        p1_in_nx         = p1_in_q;
        p2_in_nx         = p2_in_q;
        p1_data_nx       = p1_data_q;
        rom_addr_nx      = rom_addr;
        rom_en_nx        = rom_en;
        p1_pixel_data_nx = p1_pixel_data;
        p2_pixel_data_nx = p2_pixel_data;
        p1_inside_nx     = p1_inside;
        p1_visible_nx    = p1_visible;
        p2_inside_nx     = p2_inside;
        p2_visible_nx    = p2_visible;
        out_pixel_x_nx   = out_pixel_x;
        out_pixel_y_nx   = out_pixel_y;
        out_valid_nx     = 1'b0;
        overrun_nx       = overrun | (pixel_tick & (state != IDLE));

        // rom_addr only moves when a request is actually issued.
        case (state)
            IDLE: begin
                if (pixel_tick) begin
                    lat_x_nx    = current_pixel_x;
                    lat_y_nx    = current_pixel_y;
                    p1_in_nx    = p1_inside_c;
                    rom_en_nx   = p1_inside_c;
                    rom_addr_nx = p1_inside_c ? p1_addr_c : rom_addr;
                    state_nx    = FETCH_P1;
                end
            end
            FETCH_P1: begin
                p2_in_nx    = p2_inside_c;
                rom_en_nx   = p2_inside_c;
                rom_addr_nx = p2_inside_c ? p2_addr_c : rom_addr;
                state_nx    = FETCH_P2;
            end
            FETCH_P2: begin
                p1_data_nx = rom_data;
                rom_en_nx  = 1'b0;
                state_nx   = CAPTURE;
            end
            CAPTURE: begin
                p1_inside_nx     = p1_in_q;
                p1_pixel_data_nx = p1_in_q ? p1_data_q : '0;
                p1_visible_nx    = p1_in_q && (p1_data_q != TRANSPARENT_KEY);
                p2_inside_nx     = p2_in_q;
                p2_pixel_data_nx = p2_in_q ? rom_data : '0;
                p2_visible_nx    = p2_in_q && (rom_data != TRANSPARENT_KEY);
                out_pixel_x_nx   = lat_x;
                out_pixel_y_nx   = lat_y;
                out_valid_nx     = 1'b1;
                state_nx         = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_sprite_fetch_scheduler.sv
// Directed and randomized checks of sprite_fetch_scheduler against an arithmetic pixel model.
module tb_sprite_fetch_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pixel_tick = 1'b0, frame_start = 1'b0;
    logic [9:0]  current_pixel_x = '0, current_pixel_y = '0;
    logic [9:0]  p1_posx = '0, p1_posy = '0, p2_posx = '0, p2_posy = '0;
    logic [9:0]  sprite_width = '0, sprite_height = '0;
    logic [15:0] p1_frame_base = '0, p2_frame_base = '0;
    logic [15:0] rom_addr;
    logic        rom_en;
    logic [7:0]  rom_data = '0;
    logic [7:0]  p1_pixel_data, p2_pixel_data;
    logic        p1_inside, p1_visible, p2_inside, p2_visible;
    logic [9:0]  out_pixel_x, out_pixel_y;
    logic        out_valid, overrun;

    logic [7:0]  mem [0:65535];

    int vectors = 0;
    int miscompares = 0;

    int m_p1x, m_p1y, m_p2x, m_p2y, m_w, m_h, m_b1, m_b2;
    int last_addr;
    bit m_overrun;

    sprite_fetch_scheduler #(.ADDR_W(16), .TRANSPARENT_KEY(8'hFB)) dut (
        .clk(clk), .rst(rst), .pixel_tick(pixel_tick), .frame_start(frame_start),
        .current_pixel_x(current_pixel_x), .current_pixel_y(current_pixel_y),
        .p1_posx(p1_posx), .p1_posy(p1_posy), .p2_posx(p2_posx), .p2_posy(p2_posy),
        .sprite_width(sprite_width), .sprite_height(sprite_height),
        .p1_frame_base(p1_frame_base), .p2_frame_base(p2_frame_base),
        .rom_addr(rom_addr), .rom_en(rom_en), .rom_data(rom_data),
        .p1_pixel_data(p1_pixel_data), .p2_pixel_data(p2_pixel_data),
        .p1_inside(p1_inside), .p1_visible(p1_visible),
        .p2_inside(p2_inside), .p2_visible(p2_visible),
        .out_pixel_x(out_pixel_x), .out_pixel_y(out_pixel_y),
        .out_valid(out_valid), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Synchronous ROM: data one cycle after the request; junk when not enabled.
    always @(posedge clk) rom_data <= rom_en ? mem[rom_addr] : 8'($urandom);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic bit m_inside(input int x, input int y, input int px, input int py);
        return (x >= px) && (x < px + m_w) && (y >= py) && (y < py + m_h);
    endfunction

    function automatic int m_addr(input int x, input int y, input int px, input int py, input int b);
        return (b + (y - py) * m_w + (x - px)) % 65536;
    endfunction

    task automatic model_load();
        m_p1x = int'(p1_posx); m_p1y = int'(p1_posy);
        m_p2x = int'(p2_posx); m_p2y = int'(p2_posy);
        m_w   = int'(sprite_width); m_h = int'(sprite_height);
        m_b1  = int'(p1_frame_base); m_b2 = int'(p2_frame_base);
    endtask

    task automatic model_reset();
        m_p1x = 0; m_p1y = 0; m_p2x = 0; m_p2y = 0;
        m_w = 0; m_h = 0; m_b1 = 0; m_b2 = 0;
        last_addr = 0; m_overrun = 1'b0;
    endtask

    task automatic load_frame();
        frame_start = 1'b1;
        model_load();
        step();
        frame_start = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rom_en"}, 32'(rom_en), 32'd0);
        check({tag, "_rom_addr"}, 32'(rom_addr), 32'd0);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_overrun"}, 32'(overrun), 32'd0);
        check({tag, "_pixels"}, {8'(p1_pixel_data), 8'(p2_pixel_data),
              4'(p1_inside), 4'(p1_visible), 4'(p2_inside), 4'(p2_visible)}, 32'd0);
        check({tag, "_out_xy"}, {12'd0, out_pixel_x, out_pixel_y}, 32'd0);
    endtask

    // One full pixel transaction; optionally a second tick lands at n+2.
    task automatic do_pixel(input int x, input int y, input bit load, input bit second_tick);
        bit in1, in2, vis1, vis2;
        int a1, a2, d1, d2, ea1, ea2;
        if (load) model_load();
        in1 = m_inside(x, y, m_p1x, m_p1y);
        in2 = m_inside(x, y, m_p2x, m_p2y);
        a1  = m_addr(x, y, m_p1x, m_p1y, m_b1);
        a2  = m_addr(x, y, m_p2x, m_p2y, m_b2);
        d1  = in1 ? int'(mem[a1]) : 0;
        d2  = in2 ? int'(mem[a2]) : 0;
        vis1 = in1 && (d1 != 'hFB);
        vis2 = in2 && (d2 != 'hFB);
        ea1 = in1 ? a1 : last_addr;
        ea2 = in2 ? a2 : ea1;
        last_addr = ea2;

        current_pixel_x = 10'(x);
        current_pixel_y = 10'(y);
        pixel_tick = 1'b1;
        frame_start = load;
        step();
        pixel_tick = 1'b0;
        frame_start = 1'b0;
        check("n1_rom_en", 32'(rom_en), 32'(in1));
        check("n1_rom_addr", 32'(rom_addr), 32'(ea1));
        step();
        if (second_tick) begin
            pixel_tick = 1'b1;
            current_pixel_x = 10'($urandom);
            m_overrun = 1'b1;
        end
        check("n2_rom_en", 32'(rom_en), 32'(in2));
        check("n2_rom_addr", 32'(rom_addr), 32'(ea2));
        step();
        pixel_tick = 1'b0;
        check("n3_rom_en", 32'(rom_en), 32'd0);
        check("n3_out_valid", 32'(out_valid), 32'd0);
        step();
        check("n4_out_valid", 32'(out_valid), 32'd1);
        check("p1_pixel_data", 32'(p1_pixel_data), 32'(d1));
        check("p2_pixel_data", 32'(p2_pixel_data), 32'(d2));
        check("p1_flags", {30'd0, p1_inside, p1_visible}, {30'd0, in1, vis1});
        check("p2_flags", {30'd0, p2_inside, p2_visible}, {30'd0, in2, vis2});
        check("out_xy", {12'd0, out_pixel_x, out_pixel_y}, {12'd0, 10'(x), 10'(y)});
        check("overrun", 32'(overrun), 32'(m_overrun));
        step();
        check("n5_out_valid", 32'(out_valid), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++)
            mem[i] = ($urandom_range(0, 7) == 0) ? 8'hFB : 8'($urandom);
        model_reset();

        // Reset state
        step();
        step();
        check_all_zero("reset");
        rst = 1'b0;

        // Address example with frame load coinciding with the tick
        p1_posx = 10'd100; p1_posy = 10'd200; p1_frame_base = 16'h1000;
        p2_posx = 10'd600; p2_posy = 10'd400; p2_frame_base = 16'h2000;
        sprite_width = 10'd32; sprite_height = 10'd48;
        do_pixel(105, 210, 1'b1, 1'b0);
        check("lit_rom_addr_1145", 32'(rom_addr), 32'h1145);

        // Overlapping sprites
        p2_posx = 10'd104; p2_posy = 10'd205; p2_frame_base = 16'h3000;
        load_frame();
        mem[16'h128A] = 8'h1C;
        mem[16'h31E6] = 8'hE0;
        mem[16'h128B] = 8'hFB;
        do_pixel(110, 220, 1'b0, 1'b0);
        check("lit_p1_1C", 32'(p1_pixel_data), 32'h1C);
        check("lit_p2_E0", 32'(p2_pixel_data), 32'hE0);
        check("lit_vis", {30'd0, p1_visible, p2_visible}, 32'd3);

        // Transparent key
        do_pixel(111, 220, 1'b0, 1'b0);
        check("lit_key", {30'd0, p1_inside, p1_visible}, 32'd2);

        // Right-edge boundary: last column inside, next column outside
        do_pixel(131, 210, 1'b0, 1'b0);
        check("lit_x131_in", 32'(p1_inside), 32'd1);
        do_pixel(132, 210, 1'b0, 1'b0);
        check("lit_x132_out", {31'd0, p1_inside}, 32'd0);
        check("lit_x132_data", 32'(p1_pixel_data), 32'd0);

        // No wrap near the right of the coordinate range
        p1_posx = 10'd1000; p1_posy = 10'd500; sprite_width = 10'd32; sprite_height = 10'd40;
        load_frame();
        do_pixel(1010, 510, 1'b0, 1'b0);
        check("lit_nowrap_in", 32'(p1_inside), 32'd1);
        do_pixel(1023, 539, 1'b0, 1'b0);

        // Shadowing: input changes without frame_start must not take effect
        p1_posx = 10'd0; p1_posy = 10'd0; sprite_width = 10'd1023;
        do_pixel(1015, 520, 1'b0, 1'b0);

        // Overrun: second tick at n+2 ignored, sticky flag
        do_pixel(1012, 505, 1'b0, 1'b1);
        do_pixel(1005, 501, 1'b0, 1'b0);

        // Reset mid-fetch at n+2
        current_pixel_x = 10'd1011; current_pixel_y = 10'd511;
        pixel_tick = 1'b1;
        step();
        pixel_tick = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_reset();
        check_all_zero("midrst");
        for (int i = 0; i < 5; i++) begin
            step();
            check("midrst_no_valid", 32'(out_valid), 32'd0);
        end
        do_pixel(5, 5, 1'b0, 1'b0);

        // Randomized pixels against the model
        for (int it = 0; it < 60; it++) begin
            bit do_load;
            int x, y, px, py;
            do_load = (it % 6 == 0);
            if (do_load) begin
                p1_posx = 10'($urandom); p1_posy = 10'($urandom);
                p2_posx = 10'($urandom); p2_posy = 10'($urandom);
                sprite_width = 10'($urandom_range(1, 64));
                sprite_height = 10'($urandom_range(1, 64));
                p1_frame_base = 16'($urandom); p2_frame_base = 16'($urandom);
                if (it % 12 == 0) load_frame();
            end else begin
                p1_posx = 10'($urandom); sprite_height = 10'($urandom);
                p2_frame_base = 16'($urandom);
            end
            if (do_load && (it % 12 != 0)) model_load();
            px = ($urandom_range(0, 1) == 0) ? m_p1x : m_p2x;
            py = (px == m_p1x) ? m_p1y : m_p2y;
            x = px + $urandom_range(0, m_w + 3) - 2;
            y = py + $urandom_range(0, m_h + 3) - 2;
            if (x < 0) x = 0;
            if (x > 1023) x = 1023;
            if (y < 0) y = 0;
            if (y > 1023) y = 1023;
            do_pixel(x, y, do_load && (it % 12 != 0), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
